// File: rtl/invert_if.sv
// invert_if: serial operand/result pair for the bit-serial negator.
//   i : serial operand bit, LSB first (source -> negator)
//   y : registered serial result bit  (negator -> sink)
// Modports:
//   master : the serialiser side, drives i and observes y
//   slave  : the negator side, consumes i and drives y
// Clock and reset are not part of the bundle; they stay plain ports.
interface invert_if;
  logic i;
  logic y;

  modport master (output i, input y);
  modport slave  (input i, output y);
endinterface

// File: rtl/invert.sv
// invert: bit-serial two's-complement negator (y = 0 - x), LSB first.
// Bits up to and including the first 1 of a word pass through unchanged,
// and every later bit is inverted. The result bit is registered, so each
// output bit appears one cycle after its operand bit.
//
// Ports (kept in drop-in order: i, r, t_clock, y):
//   i       in  1  serial operand bit, one per rising edge of t_clock
//   r       in  1  synchronous active-high reset; also the word delimiter
//   t_clock in  1  clock, rising-edge active
//   y       out 1  registered serial result bit
//
// Parameters:
//   WORD_LEN  operand length in bits (2..64); only used with the macro below.
//
// Optional feature macro: INVERT_AUTO_REARM_EN
//   When defined, a bit counter returns the FSM to COPY after WORD_LEN
//   accepted bits so back-to-back words need no reset between them.
//   When undefined, the FSM stays in INVERT until r is asserted.
module invert #(
  parameter int unsigned WORD_LEN = 8
) (
  input  logic i,
  input  logic r,
  input  logic t_clock,
  output logic y
);

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } state_t;

  if (WORD_LEN < 2 || WORD_LEN > 64) begin : g_bad_word_len
    $error("invert: WORD_LEN must be in 2..64");
  end

  state_t state_q, state_d;
  logic   y_q, y_d;

`ifdef INVERT_AUTO_REARM_EN
  localparam int unsigned CW = $clog2(WORD_LEN);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;

    if (state_q == COPY) begin
      y_d = i;
      if (i) begin
        state_d = INVERT;
      end
    end else begin
      y_d = ~i;
    end

`ifdef INVERT_AUTO_REARM_EN
    // The last bit of a word is still output normally; only the state
    // for the following bit is forced back to COPY.
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST_BIT) begin
      cnt_d   = '0;
      state_d = COPY;
    end
`endif
  end

  always_ff @(posedge t_clock) begin
    if (r) begin
      state_q <= COPY;
      y_q     <= 1'b0;
`ifdef INVERT_AUTO_REARM_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
`ifdef INVERT_AUTO_REARM_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_invert.sv
module tb_invert;

  logic t_clock = 1'b0;
  logic r       = 1'b0;
  logic y4;

  int checks = 0;
  int errors = 0;

  invert_if sif ();

  invert #(.WORD_LEN(8)) dut (
    .i       (sif.i),
    .r       (r),
    .t_clock (t_clock),
    .y       (sif.y)
  );

  invert #(.WORD_LEN(4)) dut4 (
    .i       (sif.i),
    .r       (r),
    .t_clock (t_clock),
    .y       (y4)
  );

  always #5 t_clock = ~t_clock;

  // Apply one bit, take the edge, sample 1 time unit later.
  task automatic step(input logic in_bit, input logic rst, input logic exp, input string tag);
    sif.i = in_bit;
    r     = rst;
    @(posedge t_clock);
    #1;
    checks++;
    assert (sif.y === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, sif.y, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, "reset");
  endtask

  task automatic send_word(input logic [7:0] x, input logic [7:0] exp, input string tag);
    for (int b = 0; b < 8; b++) begin
      step(x[b], 1'b0, exp[b], $sformatf("%s bit%0d", tag, b));
    end
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] exp8;
    logic [7:0] in44;
    logic [7:0] exp44_4;
    logic [7:0] exp44_8;

    sif.i = 1'b0;
    r     = 1'b0;
    @(negedge t_clock);

    // Reset with i=1: reset wins, y=0.
    step(1'b1, 1'b1, 1'b0, "reset_with_i1");
    step(1'b1, 1'b0, 1'b1, "first_one_copied");
    step(1'b1, 1'b0, 1'b0, "after_one_inverted");

    // 0x34 -> 0xCC
    do_reset();
    send_word(8'h34, 8'hCC, "w34");

    // 0x00 -> 0x00
    do_reset();
    send_word(8'h00, 8'h00, "w00");

    // 0x80 -> 0x80 (most negative maps to itself)
    do_reset();
    send_word(8'h80, 8'h80, "w80");

    // 0x01 -> 0xFF
    do_reset();
    send_word(8'h01, 8'hFF, "w01");

    // 0xFF -> 0x01
    do_reset();
    send_word(8'hFF, 8'h01, "wFF");

    // Mid-word reset after bit 3 of 0x34: bits 0,0,1,0 -> 0,0,1,1.
    do_reset();
    step(1'b0, 1'b0, 1'b0, "mid b0");
    step(1'b0, 1'b0, 1'b0, "mid b1");
    step(1'b1, 1'b0, 1'b1, "mid b2");
    step(1'b0, 1'b0, 1'b1, "mid b3");
    step(1'b1, 1'b1, 1'b0, "mid reset_edge");
    step(1'b1, 1'b0, 1'b1, "mid new_b0");
    step(1'b1, 1'b0, 1'b0, "mid new_b1");

    // Two 4-bit words 0x4, 0x4 back to back (stream 0x44, LSB first).
    // WORD_LEN=4 instance: 0xC,0xC with auto-rearm, 0xC,0xB without.
    // WORD_LEN=8 instance sees one 8-bit word either way: -0x44 = 0xBC.
    in44    = 8'h44;
    exp44_8 = 8'hBC;
`ifdef INVERT_AUTO_REARM_EN
    exp44_4 = 8'hCC;
`else
    exp44_4 = 8'hBC;
`endif
    do_reset();
    for (int b = 0; b < 8; b++) begin
      step(in44[b], 1'b0, exp44_8[b], $sformatf("w44 len8 bit%0d", b));
      checks++;
      assert (y4 === exp44_4[b]) else begin
        errors++;
        $error("FAIL w44 len4 bit%0d: observed %b expected %b", b, y4, exp44_4[b]);
      end
    end

    // Random operands, each after a one-cycle reset.
    for (int n = 0; n < 20; n++) begin
      x    = 8'($urandom_range(0, 255));
      exp8 = 8'(9'd256 - {1'b0, x});
      do_reset();
      send_word(x, exp8, $sformatf("rnd%0d x=%02h", n, x));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/invert.md
# invert

Bit-serial two's-complement negator. Accepts one operand bit per clock, LSB first, and emits the corresponding bit of the negated value (0 − x) one cycle later. Copies bits up to and including the first 1, then inverts every following bit. Sits on serial datapaths as a negation stage between a serialiser and a downstream serial adder or deserialiser.

## Interface
- `WORD_LEN`, default 8: operand length in bits; used only when `INVERT_AUTO_REARM_EN` is defined; legal range 2..64.
- `t_clock` input 1: clock; all state updates on its rising edge.
- `r` input 1: synchronous, active-high reset; sampled on the rising edge of `t_clock`.
- `i` input 1: serial operand bit, LSB first, one bit per clock.
- `y` output 1: registered serial result bit.
- Port order for positional instantiation: `i`, `r`, `t_clock`, `y`.

## Operation
- Two-state FSM:
  - COPY: no 1 seen yet in the current word.
  - INVERT: a 1 has been seen.
- Every rising edge of `t_clock` with `r`=1:
  - state ← COPY, `y` ← 0, bit counter ← 0.
  - `i` is ignored.
- Every rising edge with `r`=0:
  - In COPY: `y` ← `i`; if `i`=1, state ← INVERT (the first 1 is passed through unchanged).
  - In INVERT: `y` ← ~`i`; state stays INVERT.
- There is no valid/enable: every non-reset edge consumes exactly one bit.
- Operand of all zeros yields all zeros (−0 = 0).
- The most negative value (10…0) yields itself; there is no overflow flag.
- `r` is the word delimiter unless `INVERT_AUTO_REARM_EN` is defined.
- The reset state is COPY, so the first bit after reset is always treated as bit 0 of a new word.

## Timing
- Latency: 1 cycle. `y` after edge n reflects `i` sampled at edge n.
- Throughput: 1 bit per cycle with no bubbles.
- Reset value: `y`=0, state=COPY. Reset takes effect on the next rising edge; no asynchronous path exists.
- Reset mid-word: the current word is abandoned, and the next non-reset edge starts a fresh word.
- `r` and `i` both 1 on the same edge: reset wins, the bit is discarded, and `y`=0.
- `y` is glitch-free; it changes only at rising edges.
- Before the first rising edge `y` is X; the bench must not check `y` before the first reset edge.

## Configuration
- Macro: `INVERT_AUTO_REARM_EN`.
- Defined:
  - A counter of ceil(log2(WORD_LEN)) bits counts accepted (non-reset) bits.
  - On the edge that accepts bit WORD_LEN−1, the output for that bit is produced normally. The state then returns to COPY and the counter to 0.
  - Back-to-back words therefore need no reset between them. `r` still clears the counter.
- Undefined:
  - No counter and no `WORD_LEN` dependence.
  - The FSM stays in INVERT until `r`.

## Test plan
- Reset: `r`=1, `i`=1 for one edge -> `y`=0, state COPY. Then `r`=0, `i`=1 -> `y`=1. Then `i`=1 -> `y`=0.
- Operand 0b00110100 (0x34) LSB first, after reset -> `y` stream LSB first = 0b11001100 (0xCC = −0x34 mod 256).
- Operand 0x00 -> output 0x00. Operand 0x80 -> output 0x80. Operand 0x01 -> output 0xFF.
- Reset asserted after bit 3 of 0x34 -> `y`=0 on the reset edge. The next bits 1,1 produce `y`=1,0 as a new word.
- `INVERT_AUTO_REARM_EN` with `WORD_LEN`=4: words 0x4, 0x4 sent back-to-back with no reset -> outputs 0xC, 0xC. Without the macro the same stream yields 0xC followed by 0xB (the FSM stays in INVERT, so the second word's bits are all inverted).
- Random 8-bit operands, each preceded by a one-cycle reset -> each output word equals (256 − x) mod 256.
